// File: rtl/vscale_alu_seq_if.sv
// rtl/vscale_alu_seq_if.sv - request/response handshake bundle for vscale_alu_seq
//
// Request channel : req_valid/req_ready with req_op, req_in1, req_in2.
// Response channel: resp_valid/resp_ready with resp_data.
// master drives requests and consumes responses; slave is the ALU side.
interface vscale_alu_seq_if #(
  parameter int XLEN     = 32,
  parameter int OP_WIDTH = 4
);
  logic                req_valid;
  logic                req_ready;
  logic [OP_WIDTH-1:0] req_op;
  logic [XLEN-1:0]     req_in1;
  logic [XLEN-1:0]     req_in2;
  logic                resp_valid;
  logic                resp_ready;
  logic [XLEN-1:0]     resp_data;

  modport master (
    output req_valid, req_op, req_in1, req_in2, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_in1, req_in2, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/vscale_alu_seq.sv
// rtl/vscale_alu_seq.sv - registered ALU with iterative shifter behind valid/ready handshakes
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   kill     synchronous flush of in-flight and held work
//   busy     high while an iterative shift is running
//   bus      slave side of vscale_alu_seq_if (request and response channels)
// Non-shift ops finish at the accept edge; shifts move up to SHIFT_STEP bits per cycle.
module vscale_alu_seq #(
  parameter int XLEN        = 32,
  parameter int SHAMT_WIDTH = 5,
  parameter int SHIFT_STEP  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  kill,
  output logic                  busy,
  vscale_alu_seq_if.slave       bus
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SLL  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_SEQ  = 4'd8;
  localparam logic [3:0] OP_SNE  = 4'd9;
  localparam logic [3:0] OP_SUB  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_SLT  = 4'd12;
  localparam logic [3:0] OP_SGE  = 4'd13;
  localparam logic [3:0] OP_SLTU = 4'd14;
  localparam logic [3:0] OP_SGEU = 4'd15;

  // Count is one bit wider than shamt so SHIFT_STEP == XLEN is representable.
  localparam int            CW     = SHAMT_WIDTH + 1;
  localparam int            STEP_W = $clog2(SHIFT_STEP);
  localparam logic [CW-1:0] STEP_V = CW'(SHIFT_STEP);

  localparam logic [1:0] K_SLL = 2'd0;
  localparam logic [1:0] K_SRL = 2'd1;
  localparam logic [1:0] K_SRA = 2'd2;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_n;
  logic [XLEN-1:0] data_q, data_n;
  logic [CW-1:0]   count_q, count_n;
  logic [1:0]      kind_q, kind_n;

  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] shifted;
  logic [CW-1:0]   step_amt;
  logic [CW-1:0]   shamt;
  logic [1:0]      req_kind;
  logic            is_shift;
  logic            accept;
  logic            load;

  assign bus.req_ready  = reset_n && !kill &&
                          (state_q == IDLE || (state_q == DONE && bus.resp_ready));
  assign bus.resp_valid = (state_q == DONE);
  assign bus.resp_data  = data_q;
  assign busy           = (state_q == SHIFT);
  assign accept         = bus.req_valid && bus.req_ready;
  assign shamt          = {1'b0, bus.req_in2[SHAMT_WIDTH-1:0]};

  always_comb begin
    alu_res  = '0;
    is_shift = 1'b0;
    req_kind = K_SLL;
    case (bus.req_op)
      OP_ADD:  alu_res = bus.req_in1 + bus.req_in2;
      OP_SUB:  alu_res = bus.req_in1 - bus.req_in2;
      OP_XOR:  alu_res = bus.req_in1 ^ bus.req_in2;
      OP_OR:   alu_res = bus.req_in1 | bus.req_in2;
      OP_AND:  alu_res = bus.req_in1 & bus.req_in2;
      OP_SEQ:  alu_res = XLEN'(bus.req_in1 == bus.req_in2);
      OP_SNE:  alu_res = XLEN'(bus.req_in1 != bus.req_in2);
      OP_SLT:  alu_res = XLEN'($signed(bus.req_in1) <  $signed(bus.req_in2));
      OP_SGE:  alu_res = XLEN'($signed(bus.req_in1) >= $signed(bus.req_in2));
      OP_SLTU: alu_res = XLEN'(bus.req_in1 <  bus.req_in2);
      OP_SGEU: alu_res = XLEN'(bus.req_in1 >= bus.req_in2);
      OP_SLL:  begin is_shift = 1'b1; req_kind = K_SLL; end
      OP_SRL:  begin is_shift = 1'b1; req_kind = K_SRL; end
      OP_SRA:  begin is_shift = 1'b1; req_kind = K_SRA; end
      default: alu_res = '0;
    endcase
  end

  // Shifter only spans 0..SHIFT_STEP: a binary-weighted chain over the
  // low STEP_W+1 bits of the step amount. SRA keeps the sign bit in place,
  // so repeated arithmetic steps fill with the original in1 MSB.
  always_comb begin
    step_amt = (count_q >= STEP_V) ? STEP_V : count_q;
    shifted  = data_q;
    for (int b = 0; b <= STEP_W; b++) begin
      if (step_amt[b]) begin
        case (kind_q)
          K_SRL:   shifted = shifted >> (1 << b);
          K_SRA:   shifted = $unsigned($signed(shifted) >>> (1 << b));
          default: shifted = shifted << (1 << b);
        endcase
      end
    end
  end

  always_comb begin
    state_n = state_q;
    data_n  = data_q;
    count_n = count_q;
    kind_n  = kind_q;
    load    = 1'b0;
    if (kill) begin
      state_n = IDLE;
    end else begin
      case (state_q)
        IDLE: load = accept;
        SHIFT: begin
          data_n  = shifted;
          count_n = count_q - step_amt;
          if (count_q == step_amt) state_n = DONE;
        end
        DONE: begin
          if (bus.resp_ready) begin
            state_n = IDLE;
            load    = accept;
          end
        end
        default: state_n = IDLE;
      endcase
      if (load) begin
        if (is_shift) begin
          data_n  = bus.req_in1;
          count_n = shamt;
          kind_n  = req_kind;
          state_n = (shamt == '0) ? DONE : SHIFT;
        end else begin
          data_n  = alu_res;
          state_n = DONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      count_q <= '0;
      kind_q  <= K_SLL;
    end else begin
      state_q <= state_n;
      data_q  <= data_n;
      count_q <= count_n;
      kind_q  <= kind_n;
    end
  end

endmodule

// File: doc/vscale_alu_seq.md
Name: vscale_alu_seq

Overview:
- Parametrised, registered successor to the combinational ALU, for the execute stage of wider or area-constrained vscale variants.
- Accepts one operation per request over a valid/ready handshake and returns a registered result over a second valid/ready handshake.
- Logical, arithmetic and compare ops complete in 1 cycle.
- Shifts run on an iterative shifter that moves SHIFT_STEP bits per cycle, so shifter area scales with SHIFT_STEP.
- A kill input flushes in-flight work on pipeline redirect.

Parameters:
- XLEN, 32, operand and result width; power of two, 8 to 64.
- SHAMT_WIDTH, 5, shift-amount width; must equal log2(XLEN).
- SHIFT_STEP, 1, bits shifted per iteration cycle; power of two, 1 to XLEN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_op  in  `ALU_OP_WIDTH  operation code; `ALU_OP_* encodings from vscale_alu_ops.vh.
- req_in1  in  XLEN  operand 1.
- req_in2  in  XLEN  operand 2; for shifts, shamt = req_in2[SHAMT_WIDTH-1:0].
- resp_valid  out  1  result held in output register.
- resp_ready  in  1  consumer takes result this cycle.
- resp_data  out  XLEN  result.
- kill  in  1  synchronous flush of in-flight and held work.
- busy  out  1  high in SHIFT state.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, resp_valid=0, resp_data=0, busy=0, internal count=0. Reset mid-shift abandons the operation; no response is produced.
- States: IDLE, SHIFT, DONE.
- req_ready = !kill && (state==IDLE || (state==DONE && resp_ready)). A request is accepted on an edge where req_valid && req_ready.
- Non-shift ops: ADD, SUB, XOR, OR, AND, SEQ, SNE, SLT, SGE, SLTU, SGEU.
  - Result is computed from the request and registered at the accept edge; state goes to DONE. Latency is 1 cycle.
  - Compare results are zero-extended to XLEN (bit 0 = result).
  - ADD/SUB wrap modulo 2^XLEN.
  - Unknown op code gives result 0, latency 1.
- Shift ops: SLL, SRL, SRA.
  - At the accept edge, load the working register with in1 and set count=shamt.
  - shamt==0: go directly to DONE with result in1 (latency 1).
  - Otherwise go to SHIFT. On each SHIFT edge, shift by min(SHIFT_STEP, count) and decrement count by the same amount. When count reaches 0, go to DONE.
  - Latency = 1 + ceil(shamt/SHIFT_STEP) cycles.
  - SRA fills with the original in1[XLEN-1]; SLL/SRL fill with 0.
  - req_ready=0 throughout SHIFT.
- DONE: resp_valid=1 and resp_data stable until resp_ready.
  - On a handshake edge, a new request accepted on the same edge loads its result or shift setup (back-to-back, no bubble).
  - With no new request, state goes to IDLE and resp_valid=0.
- kill (highest priority below reset): on an edge with kill=1, state goes to IDLE, resp_valid=0, busy=0. Any held result is dropped even if resp_ready is high that cycle. Because req_ready is forced 0, no request is accepted on that edge.
- resp_data holds its last value when resp_valid=0 (don't-care to consumers).
- Operands are captured at accept; later changes on req_* have no effect.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> resp_valid=0, resp_data=0, req_ready=0 during reset; req_ready=1 at first cycle after release.
- ADD back-to-back, resp_ready=1: ADD 0xFFFFFFFF+1 then SUB 0-1 on consecutive cycles -> resp_data 0x00000000 then 0xFFFFFFFF, one result per cycle, no bubbles.
- Compares: SLT(0x80000000,1)=1, SLTU(0x80000000,1)=0, SGE(-1,-1)=1, SNE(5,5)=0, all zero-extended.
- Iterative shift, SHIFT_STEP=1: SRA 0x80000000 by 31 -> busy for 31 cycles, resp_valid at cycle 32, resp_data=0xFFFFFFFF. Repeat with SHIFT_STEP=8, SLL 1 by 17 -> latency 4, result 0x00020000. shamt=0 -> latency 1, result=in1.
- Backpressure: resp_ready=0 for 5 cycles after an OR result -> resp_valid and resp_data held stable, req_ready=0; result released on first resp_ready=1.
- Kill: assert kill mid-SHIFT, and separately in DONE with resp_ready=1 and req_valid=1 -> no response emitted, no request accepted that edge, IDLE next cycle, following request completes normally.
